// File: rtl/tt_selftest_pkg.sv
// Shared types and constants for the Tiny Tapeout self-test harness.
// FSM state encoding, default Galois tap masks and the LFSR lockup-guard seed.
package tt_selftest_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Maximal-length Galois tap masks (right-shifting form).
  localparam logic [7:0]  POLY8  = 8'hB8;
  localparam logic [15:0] POLY16 = 16'hB400;
  localparam logic [31:0] POLY32 = 32'h8020_0003;

  // An all-zero LFSR never leaves zero; this replaces a zero seed.
  localparam int LOCKUP_SEED = 1;

endpackage

// File: rtl/tt_galois_shift.sv
// Right-shifting Galois shift register with parallel load and data fold-in.
// Used as the stimulus LFSR (d tied to 0) and as the response MISR.
module tt_galois_shift #(
  parameter int            W    = 8,
  parameter logic [W-1:0]  POLY = W'(8'hB8)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= load_val;
    else if (step) q <= (q >> 1) ^ (q[0] ? POLY : '0) ^ d;
  end

endmodule

// File: rtl/tt_selftest_harness.sv
// LFSR-stimulus / MISR-signature self-test harness around a user core.
// Optional build macro SELFTEST_SIG_OUT_EN exposes the live MISR as sig_o.
module tt_selftest_harness
  import tt_selftest_pkg::*;
#(
  parameter int                DIN_W     = 8,
  parameter int                DOUT_W    = 8,
  parameter logic [DIN_W-1:0]  LFSR_POLY = DIN_W'(POLY8),
  parameter logic [DOUT_W-1:0] MISR_POLY = DOUT_W'(POLY8),
  parameter int                NUM_VEC   = 256,
  parameter int                PIPE_LAT  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DIN_W-1:0]             seed_i,
  input  logic [DOUT_W-1:0]            exp_sig_i,
  output logic [DIN_W-1:0]             stim_o,
  input  logic [DOUT_W-1:0]            resp_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [$clog2(NUM_VEC+1)-1:0] vec_cnt_o
`ifdef SELFTEST_SIG_OUT_EN
  ,output logic [DOUT_W-1:0]           sig_o
`endif
);

  localparam int CW = $clog2(NUM_VEC+1);
  localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT+1) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     vec_cnt_q;
  logic [DW-1:0]     drain_cnt_q;
  logic [DOUT_W-1:0] exp_q;
  logic [DIN_W-1:0]  lfsr_q, seed_safe;
  logic [DOUT_W-1:0] misr_q;
  logic [PIPE_LAT:0] vld_pipe;
  logic              accept, in_run, last_vec, last_drain, capture;

  assign in_run     = (state_q == RUN);
  assign accept     = start && (state_q == IDLE || state_q == DONE);
  assign last_vec   = in_run && (vec_cnt_q == CW'(NUM_VEC-1));
  assign last_drain = (state_q == DRAIN) && (drain_cnt_q == DW'(PIPE_LAT-1));
  assign seed_safe  = (seed_i == '0) ? DIN_W'(LOCKUP_SEED) : seed_i;

  // Valid tags track each applied vector through the DUT latency; the tail
  // of the delay line marks the cycle its response is on resp_i.
  generate
    if (PIPE_LAT > 0) begin : g_pipe
      logic [PIPE_LAT-1:0] vld_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_pipe[PIPE_LAT-1:0];
      end
      assign vld_pipe = {vld_q, in_run};
    end else begin : g_comb
      assign vld_pipe = in_run;
    end
  endgenerate

  assign capture = vld_pipe[PIPE_LAT];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start)      state_d = RUN;
      RUN:        if (last_vec)   state_d = (PIPE_LAT == 0) ? DONE : DRAIN;
      DRAIN:      if (last_drain) state_d = DONE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_cnt_q   <= '0;
      drain_cnt_q <= '0;
      exp_q       <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + 1'b1 : '0;
      if (accept)
        vec_cnt_q <= '0;
      else if (in_run && vec_cnt_q != CW'(NUM_VEC))
        vec_cnt_q <= vec_cnt_q + 1'b1;
      if (state_d == DONE && state_q != DONE)
        exp_q <= exp_sig_i;
    end
  end

  tt_galois_shift #(.W(DIN_W), .POLY(LFSR_POLY)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (seed_safe),
    .step     (in_run),
    .d        ('0),
    .q        (lfsr_q)
  );

  tt_galois_shift #(.W(DOUT_W), .POLY(MISR_POLY)) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ('0),
    .step     (capture),
    .d        (resp_i),
    .q        (misr_q)
  );

  // The MISR is frozen in DONE, so the compare can stay combinational.
  assign stim_o    = in_run ? lfsr_q : '0;
  assign busy_o    = (state_q == RUN) || (state_q == DRAIN);
  assign done_o    = (state_q == DONE);
  assign pass_o    = done_o && (misr_q == exp_q);
  assign vec_cnt_o = vec_cnt_q;
`ifdef SELFTEST_SIG_OUT_EN
  assign sig_o     = misr_q;
`endif

endmodule

// File: tb/tb_tt_selftest_harness.sv
// Directed bench: u_a (4 vectors, 2-cycle DUT) and u_b (255 vectors, combinational loopback).
module tb_tt_selftest_harness;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] seed_a = '0, seed_b = '0, exp_a = '0, exp_b = '0;
  logic [7:0] stim_a, stim_b, resp_a, resp_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [2:0] cnt_a;
  logic [7:0] cnt_b;
`ifdef SELFTEST_SIG_OUT_EN
  logic [7:0] sig_a, sig_b;
`endif

  logic       loop_a = 1'b0;
  logic [7:0] resp_const = '0;
  logic [7:0] d1, d2;
  int         n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  // Models a 2-cycle DUT that swaps nibbles of its input.
  always @(posedge clk) begin
    d1 <= {stim_a[3:0], stim_a[7:4]};
    d2 <= d1;
  end
  assign resp_a = loop_a ? d2 : resp_const;
  assign resp_b = stim_b;

  tt_selftest_harness #(.NUM_VEC(4), .PIPE_LAT(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .seed_i(seed_a), .exp_sig_i(exp_a),
    .stim_o(stim_a), .resp_i(resp_a), .busy_o(busy_a), .done_o(done_a),
    .pass_o(pass_a), .vec_cnt_o(cnt_a)
`ifdef SELFTEST_SIG_OUT_EN
    , .sig_o(sig_a)
`endif
  );

  tt_selftest_harness #(.NUM_VEC(255), .PIPE_LAT(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .seed_i(seed_b), .exp_sig_i(exp_b),
    .stim_o(stim_b), .resp_i(resp_b), .busy_o(busy_b), .done_o(done_b),
    .pass_o(pass_b), .vec_cnt_o(cnt_b)
`ifdef SELFTEST_SIG_OUT_EN
    , .sig_o(sig_b)
`endif
  );

  function automatic logic [7:0] gstep(input logic [7:0] r, input logic [7:0] d);
    return (r >> 1) ^ (r[0] ? 8'hB8 : 8'h00) ^ d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [7:0] seed, input logic [7:0] expv);
    seed_a = seed; exp_a = expv; start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    int k = 0;
    while (done_a !== 1'b1 && k < 40) begin tick(); k++; end
    n_total++;
    if (done_a !== 1'b1) $display("FAIL done_a_timeout: done=%b want 1", done_a); else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1; resp_const = 8'hFF;
    tick(); tick();
    n_total++; if (stim_a !== 8'h00) $display("FAIL rst_stim: got %h want 00", stim_a); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_a); else n_pass++;
    n_total++; if (done_a !== 1'b0) $display("FAIL rst_done: got %b want 0", done_a); else n_pass++;
    n_total++; if (pass_a !== 1'b0) $display("FAIL rst_pass: got %b want 0", pass_a); else n_pass++;
    n_total++; if (cnt_a !== 3'd0) $display("FAIL rst_cnt: got %0d want 0", cnt_a); else n_pass++;
    n_total++; if (busy_b !== 1'b0) $display("FAIL rst_busy_b: got %b want 0", busy_b); else n_pass++;
    start_a = 1'b0; start_b = 1'b0;
    @(negedge clk); rst = 1'b0;
    tick(); tick(); tick();
    n_total++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL idle_hold: busy=%b done=%b want 0 0", busy_a, done_a); else n_pass++;
    n_total++; if (stim_a !== 8'h00) $display("FAIL idle_stim: got %h want 00", stim_a); else n_pass++;
  endtask

  task automatic test_sequence();
    logic [7:0] want [4];
    want[0] = 8'h01; want[1] = 8'hB8; want[2] = 8'h5C; want[3] = 8'h2E;
    resp_const = 8'h00;
    run_a(8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (stim_a !== want[i]) $display("FAIL seq_stim%0d: got %h want %h", i + 1, stim_a, want[i]); else n_pass++;
      tick();
    end
    wait_done_a();
  endtask

  task automatic test_timing();
    run_a(8'h33, 8'h00);
    for (int c = 1; c <= 8; c++) begin
      n_total++;
      if (busy_a !== (c <= 6)) $display("FAIL tim_busy c%0d: got %b want %b", c, busy_a, (c <= 6)); else n_pass++;
      n_total++;
      if (done_a !== (c >= 7)) $display("FAIL tim_done c%0d: got %b want %b", c, done_a, (c >= 7)); else n_pass++;
      n_total++;
      if (cnt_a !== 3'((c - 1 < 4) ? c - 1 : 4)) $display("FAIL tim_cnt c%0d: got %0d want %0d", c, cnt_a, (c - 1 < 4) ? c - 1 : 4); else n_pass++;
      if (c == 5) begin
        n_total++;
        if (stim_a !== 8'h00) $display("FAIL drain_stim: got %h want 00", stim_a); else n_pass++;
      end
      start_a = (c == 3);
      tick();
    end
    start_a = 1'b0;
  endtask

  task automatic test_signature();
`ifdef SELFTEST_SIG_OUT_EN
    logic [7:0] sig_tab [8];
    sig_tab[1] = 8'h00; sig_tab[2] = 8'h00; sig_tab[3] = 8'h00; sig_tab[4] = 8'hA5;
    sig_tab[5] = 8'h38; sig_tab[6] = 8'hF6; sig_tab[7] = 8'h0E; sig_tab[0] = 8'h00;
`endif
    loop_a = 1'b0; resp_const = 8'h00;
    run_a(8'h5A, 8'h00);
    n_total++; if (done_a !== 1'b0 || pass_a !== 1'b0) $display("FAIL restart_clear: done=%b pass=%b want 0 0", done_a, pass_a); else n_pass++;
    wait_done_a();
    n_total++; if (pass_a !== 1'b1) $display("FAIL sig_zero_pass: got %b want 1", pass_a); else n_pass++;
    run_a(8'h5A, 8'h01);
    wait_done_a();
    n_total++; if (pass_a !== 1'b0) $display("FAIL sig_zero_miss: got %b want 0", pass_a); else n_pass++;
    // Stimulus 5A,2D,AE,57 -> responses A5,D2,EA,75 -> signature 0E.
    loop_a = 1'b1;
    run_a(8'h5A, 8'h0E);
    for (int c = 1; c <= 7; c++) begin
`ifdef SELFTEST_SIG_OUT_EN
      n_total++;
      if (sig_a !== sig_tab[c]) $display("FAIL sig_o c%0d: got %h want %h", c, sig_a, sig_tab[c]); else n_pass++;
`endif
      if (c < 7) tick();
    end
    n_total++; if (done_a !== 1'b1) $display("FAIL loop_done: got %b want 1", done_a); else n_pass++;
    n_total++; if (pass_a !== 1'b1) $display("FAIL loop_pass: got %b want 1", pass_a); else n_pass++;
    run_a(8'h5A, 8'h0F);
    wait_done_a();
    n_total++; if (pass_a !== 1'b0) $display("FAIL loop_miss: got %b want 0", pass_a); else n_pass++;
    loop_a = 1'b0;
  endtask

  task automatic test_period();
    logic [255:0] seen = '0;
    logic [7:0]   l = 8'h01, m = 8'h00, last = 8'h00;
    int           k = 0;
    for (int i = 0; i < 255; i++) begin
      m = gstep(m, l);
      l = gstep(l, 8'h00);
    end
    seed_b = 8'h01; exp_b = m; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 255; i++) begin
      n_total++;
      if (stim_b === 8'h00 || seen[stim_b]) $display("FAIL period_vec%0d: got %h (zero or repeat)", i + 1, stim_b);
      else n_pass++;
      seen[stim_b] = 1'b1;
      last = stim_b;
      tick();
    end
    while (done_b !== 1'b1 && k < 10) begin tick(); k++; end
    n_total++; if (k != 0) $display("FAIL period_done_lat: extra cycles %0d want 0", k); else n_pass++;
    n_total++; if (last !== 8'h02) $display("FAIL period_last: got %h want 02", last); else n_pass++;
    n_total++; if (cnt_b !== 8'd255) $display("FAIL period_cnt: got %0d want 255", cnt_b); else n_pass++;
    n_total++; if (pass_b !== 1'b1) $display("FAIL period_pass: got %b want 1", pass_b); else n_pass++;
  endtask

  task automatic test_abort();
    int k = 0;
    seed_b = 8'h01; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    n_total++; if (busy_b !== 1'b1 || cnt_b !== 8'd9) $display("FAIL abort_pre: busy=%b cnt=%0d want 1 9", busy_b, cnt_b); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++; if (busy_b !== 1'b0 || stim_b !== 8'h00 || cnt_b !== 8'd0) $display("FAIL abort_clear: busy=%b stim=%h cnt=%0d want 0 00 0", busy_b, stim_b, cnt_b); else n_pass++;
    n_total++; if (done_a !== 1'b0 || pass_a !== 1'b0) $display("FAIL abort_a: done=%b pass=%b want 0 0", done_a, pass_a); else n_pass++;
    @(negedge clk); rst = 1'b0;
    tick();
    loop_a = 1'b1;
    run_a(8'h5A, 8'h0E);
    wait_done_a();
    n_total++; if (pass_a !== 1'b1) $display("FAIL abort_rerun_a: got %b want 1", pass_a); else n_pass++;
    loop_a = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    while (done_b !== 1'b1 && k < 300) begin tick(); k++; end
    n_total++; if (done_b !== 1'b1 || pass_b !== 1'b1) $display("FAIL abort_rerun_b: done=%b pass=%b want 1 1", done_b, pass_b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_timing();
    test_signature();
    test_period();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
